// File: rtl/fifo_sync.sv
// Single-clock first-word-fall-through FIFO over a DEPTH-entry circular buffer.
// Flags and level come from registered state only; clear_i flushes pointers synchronously.
module fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    if (WIDTH < 1 || DEPTH < 2) begin : g_bad_param
        $error("fifo_sync: WIDTH must be >= 1 and DEPTH >= 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    level;
    logic [PW-1:0]    wr_ptr_next;
    logic [PW-1:0]    rd_ptr_next;
    logic [LW-1:0]    level_next;
    logic             push_acc;
    logic             pop_acc;

    // Explicit wrap so non-power-of-two depths never index past the array.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign full_o   = (level == FULL_LVL);
    assign empty_o  = (level == '0);
    assign level_o  = level;
    assign push_acc = push_i & ~full_o;
    assign pop_acc  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        level_next  = level;
        if (clear_i) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            level_next  = '0;
        end else begin
            if (push_acc) wr_ptr_next = ptr_inc(wr_ptr);
            if (pop_acc)  rd_ptr_next = ptr_inc(rd_ptr);
            unique case ({push_acc, pop_acc})
                2'b10:   level_next = level + LW'(1);
                2'b01:   level_next = level - LW'(1);
                default: level_next = level;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= wr_ptr_next;
            rd_ptr <= rd_ptr_next;
            level  <= level_next;
        end
    end

    // Storage is never reset; a write during clear is pointless since the pointers restart.
    always_ff @(posedge clk_i) begin
        if (push_acc && !clear_i) mem[wr_ptr] <= wdata_i;
    end

    assign rdata_o = mem[rd_ptr];

endmodule

// File: tb/tb_fifo_sync.sv
// Bench for fifo_sync: DEPTH=4 vector table plus corner sequences, DEPTH=3 wrap stream.
module tb_fifo_sync;

    logic       clk;
    logic       rst_n;
    logic       clr4, push4, pop4;
    logic [7:0] wd4, rd4;
    logic       full4, empty4;
    logic [2:0] lvl4;
    logic       clr3, push3, pop3;
    logic [7:0] wd3, rd3;
    logic       full3, empty3;
    logic [1:0] lvl3;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] q4[$];
    logic [7:0] q3[$];

    typedef struct {
        logic       push;
        logic       pop;
        logic       clr;
        logic [7:0] wd;
        int         lvl;
        logic       emp;
        logic       ful;
    } vec_t;

    vec_t tbl[$];

    fifo_sync #(.WIDTH(8), .DEPTH(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clr4), .push_i(push4), .wdata_i(wd4),
        .pop_i(pop4), .rdata_o(rd4), .full_o(full4), .empty_o(empty4), .level_o(lvl4)
    );

    fifo_sync #(.WIDTH(8), .DEPTH(3)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clr3), .push_i(push3), .wdata_i(wd3),
        .pop_i(pop3), .rdata_o(rd3), .full_o(full3), .empty_o(empty3), .level_o(lvl3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle on the DEPTH=4 instance; the scoreboard checks head data before the edge.
    task automatic step4(input logic push, input logic pop, input logic clr, input logic [7:0] wd);
        bit pa, pp;
        push4 = push; pop4 = pop; clr4 = clr; wd4 = wd;
        pa = push && !clr && (q4.size() < 4);
        pp = pop && !clr && (q4.size() > 0);
        if (pp)
            chk("pop_data", {24'h0, rd4}, {24'h0, q4.pop_front()});
        else if (q4.size() > 0)
            chk("head_data", {24'h0, rd4}, {24'h0, q4[0]});
        if (clr) q4.delete();
        else if (pa) q4.push_back(wd);
        @(posedge clk);
        #1;
        push4 = 1'b0; pop4 = 1'b0; clr4 = 1'b0;
    endtask

    task automatic chk_flags4(input string tag, input int lvl, input logic emp, input logic ful);
        chk({tag, "_level"}, {29'h0, lvl4}, lvl);
        chk({tag, "_empty"}, {31'h0, empty4}, {31'h0, emp});
        chk({tag, "_full"},  {31'h0, full4},  {31'h0, ful});
    endtask

    initial begin
        int sent;
        logic [7:0] nxt;
        rst_n = 1'b0;
        clr4 = 0; push4 = 0; pop4 = 0; wd4 = '0;
        clr3 = 0; push3 = 0; pop3 = 0; wd3 = '0;

        // Table: push, pop, clr, wdata, expected level/empty/full after the edge.
        tbl.push_back('{1, 0, 0, 8'h11, 1, 0, 0});
        tbl.push_back('{1, 0, 0, 8'h22, 2, 0, 0});
        tbl.push_back('{1, 0, 0, 8'h33, 3, 0, 0});
        tbl.push_back('{1, 0, 0, 8'h44, 4, 0, 1});
        tbl.push_back('{1, 0, 0, 8'h55, 4, 0, 1});
        tbl.push_back('{1, 1, 0, 8'h66, 3, 0, 0});
        tbl.push_back('{0, 1, 0, 8'h00, 2, 0, 0});
        tbl.push_back('{0, 1, 0, 8'h00, 1, 0, 0});
        tbl.push_back('{0, 1, 0, 8'h00, 0, 1, 0});
        tbl.push_back('{0, 1, 0, 8'h00, 0, 1, 0});
        tbl.push_back('{1, 1, 0, 8'h77, 1, 0, 0});
        tbl.push_back('{1, 0, 0, 8'h88, 2, 0, 0});
        tbl.push_back('{1, 1, 0, 8'h99, 2, 0, 0});
        tbl.push_back('{1, 0, 0, 8'hA1, 3, 0, 0});
        tbl.push_back('{1, 0, 1, 8'h5A, 0, 1, 0});
        tbl.push_back('{1, 0, 0, 8'hAB, 1, 0, 0});
        tbl.push_back('{0, 1, 0, 8'h00, 0, 1, 0});

        #3;
        chk_flags4("reset", 0, 1'b1, 1'b0);
        chk("reset3_level", {30'h0, lvl3}, 32'h0);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            step4(tbl[i].push, tbl[i].pop, tbl[i].clr, tbl[i].wd);
            chk_flags4($sformatf("vec%0d", i), tbl[i].lvl, tbl[i].emp, tbl[i].ful);
        end

        // Asynchronous reset with two entries held: flags must drop without a clock edge.
        step4(1, 0, 0, 8'hD1);
        step4(1, 0, 0, 8'hD2);
        chk_flags4("pre_rst", 2, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_flags4("async_rst", 0, 1'b1, 1'b0);
        q4.delete();
        #1 rst_n = 1'b1;
        step4(1, 0, 0, 8'hC3);
        chk_flags4("post_rst", 1, 1'b0, 1'b0);
        step4(0, 1, 0, 8'h00);
        chk_flags4("post_rst_pop", 0, 1'b1, 1'b0);

        // DEPTH=3 wrap stream: ten entries, level kept within 1..3 until the drain.
        sent = 0;
        nxt  = 8'h40;
        for (int c = 0; c < 100; c++) begin
            bit pa, pp, rnd;
            if (sent == 10 && q3.size() == 0) break;
            rnd = bit'($urandom_range(0, 1));
            pa = (sent < 10) && (q3.size() < 3);
            pp = (q3.size() == 3) || (q3.size() >= 2 && rnd) || (sent == 10 && q3.size() > 0);
            push3 = pa; pop3 = pp; wd3 = nxt;
            if (pp) chk("wrap_data", {24'h0, rd3}, {24'h0, q3.pop_front()});
            if (pa) begin
                q3.push_back(nxt);
                nxt = nxt + 8'h07;
                sent++;
            end
            @(posedge clk);
            #1;
            push3 = 1'b0; pop3 = 1'b0;
            chk("wrap_level", {30'h0, lvl3}, q3.size());
            if (lvl3 > 2'd3) chk("wrap_level_max", {30'h0, lvl3}, 32'd3);
        end
        chk("wrap_count", sent, 32'd10);
        chk("wrap_empty", {31'h0, empty3}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fifo_sync.md
FIFO_SYNC -- requirements
Module: fifo_sync

Interface
REQ-001 Parameter WIDTH, default 8: bits per entry; SHALL be >= 1.
REQ-002 Parameter DEPTH, default 16: number of entries; SHALL be >= 2 and need not be a power of two.
REQ-003 LW (derived, not overridable) SHALL equal $clog2(DEPTH+1), so the count 0..DEPTH is representable.
REQ-004 Reset is rst_ni, asynchronous, active-low; clock is clk_i.
REQ-005 Ports SHALL be exactly as follows (name, direction, width, meaning):
- clk_i  in  1  rising-edge clock.
- rst_ni  in  1  async active-low reset.
- clear_i  in  1  synchronous flush.
- push_i  in  1  write request.
- wdata_i  in  WIDTH  write data.
- pop_i  in  1  read/advance request.
- rdata_o  out  WIDTH  head-of-queue data (first-word-fall-through).
- full_o  out  1  level == DEPTH.
- empty_o  out  1  level == 0.
- level_o  out  LW  current occupancy.

Function
REQ-006 Single-clock circular buffer of DEPTH x WIDTH; write and read pointers wrap from DEPTH-1 to 0.
REQ-007 rdata_o SHALL combinationally present the oldest stored entry (mem[rd_ptr]) whenever empty_o=0, with zero-cycle latency and no pop required to view it.
REQ-008 When empty_o=1, rdata_o value is unspecified but SHALL NOT be X-propagating from pointers; benches SHALL NOT check it.
REQ-009 full_o, empty_o and level_o SHALL be decoded from registered state only, with no combinational path from push_i, pop_i or clear_i.
REQ-010 Push accepted = push_i & !full_o: the entry is written at wr_ptr on the clock edge, wr_ptr advances, and a word is visible on rdata_o the next cycle if the FIFO was empty.
REQ-011 Push while full_o=1 SHALL be ignored, even with a simultaneous pop: no write, no pointer change from the push, stored data intact.
REQ-012 Pop accepted = pop_i & !empty_o: rd_ptr advances and the next entry appears on rdata_o the following cycle.
REQ-013 Pop while empty_o=1 SHALL be ignored, even with a simultaneous push: the pushed entry is stored and the level becomes 1.
REQ-014 Simultaneous accepted push and pop SHALL leave the level unchanged, with both pointers advancing.
REQ-015 Level update: level_next = level + push_acc - pop_acc; it SHALL never exceed DEPTH nor go below 0.
REQ-016 clear_i=1 SHALL, at the clock edge, reset both pointers and level to 0 with priority over push_i/pop_i in the same cycle; an entry pushed in the clear cycle is discarded.
REQ-017 Memory contents need not be reset or cleared; only pointers and level are.
REQ-018 The FIFO SHALL provide no error outputs; overflow/underflow detection is the instantiator's responsibility.

Reset
REQ-019 While rst_ni=0: wr_ptr=0, rd_ptr=0, level_o=0, empty_o=1, full_o=0, asynchronously.
REQ-020 Reset asserted mid-operation SHALL discard all content; after release the FIFO behaves as freshly empty.
REQ-021 Release of reset SHALL be synchronous-safe: the first accepted push is on the first rising edge with rst_ni=1.

Verification
REQ-022 WIDTH=8, DEPTH=4: push 0x11,0x22,0x33,0x44 on consecutive cycles -> level 1,2,3,4; full_o=1 after the 4th; rdata_o=0x11 from the cycle after the first push.
REQ-023 From full: push 0x55 with no pop -> ignored, level stays 4; then pop four times -> rdata_o sequence 0x11,0x22,0x33,0x44, then empty_o=1, level 0.
REQ-024 Wrap: with DEPTH=3 (non-power-of-two), stream 10 entries with interleaved push/pop keeping level 1..3 -> output order equals input order and level never exceeds 3.
REQ-025 Level 2, push_i=1 and pop_i=1 in the same cycle -> level stays 2 and rdata_o advances to the next-oldest entry; when empty, push+pop -> level becomes 1 and rdata_o equals the pushed data.
REQ-026 Level 3, assert clear_i together with push_i -> next cycle level 0, empty_o=1; the pushed data is not retained, and a subsequent push of 0xAB appears on rdata_o.
REQ-027 Assert rst_ni=0 asynchronously with level 2 -> empty_o=1 and level_o=0 immediately, without waiting for a clock edge.
